// File: rtl/as2650_sram_arbiter_if.sv
// rtl/as2650_sram_arbiter_if.sv - CPU port A, debug port B and macro pin bundle for the SRAM arbiter
interface as2650_sram_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) ();
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_wbmask;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic              ram_cen;
    logic              ram_gwen;
    logic [DATA_W-1:0] ram_wen;
    logic [ADDR_W-1:0] ram_a;
    logic [DATA_W-1:0] ram_d;
    logic [DATA_W-1:0] ram_q;

    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata, b_wbmask,
        input  ram_q,
        output a_ack, a_rdata, b_ack, b_rdata,
        output ram_cen, ram_gwen, ram_wen, ram_a, ram_d,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata, b_wbmask,
        output ram_q,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  ram_cen, ram_gwen, ram_wen, ram_a, ram_d,
        input  busy
    );
endinterface

// File: rtl/as2650_sram_arbiter.sv
// rtl/as2650_sram_arbiter.sv - two-port round-robin arbiter/sequencer for the 512x8 SRAM macro
// Optional post-reset zeroing sweep enabled by SRAM_ARB_CLEAR_EN.
module as2650_sram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    as2650_sram_arbiter_if.slave bus
);
    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_CMD   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;

`ifdef SRAM_ARB_CLEAR_EN
    localparam logic [2:0] ST_RESET = ST_CLEAR;
`else
    localparam logic [2:0] ST_RESET = ST_IDLE;
`endif

    logic [2:0]        state;
    logic              last_b;
    logic              gnt_b;
    logic              is_rd;
    logic              ram_cen;
    logic              ram_gwen;
    logic [DATA_W-1:0] ram_wen;
    logic [ADDR_W-1:0] ram_a;
    logic [DATA_W-1:0] ram_d;
    logic              a_ack;
    logic              b_ack;
    logic [DATA_W-1:0] a_rdata;
    logic [DATA_W-1:0] b_rdata;
`ifdef SRAM_ARB_CLEAR_EN
    logic [ADDR_W:0]   clr_cnt;
`endif

    // A wins when B is idle or when B took the previous grant.
    logic grant_a;
    assign grant_a = bus.a_req && (!bus.b_req || last_b);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_RESET;
            last_b   <= 1'b1;
            gnt_b    <= 1'b0;
            is_rd    <= 1'b0;
            ram_cen  <= 1'b1;
            ram_gwen <= 1'b1;
            ram_wen  <= '1;
            ram_a    <= '0;
            ram_d    <= '0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
`ifdef SRAM_ARB_CLEAR_EN
            clr_cnt  <= '0;
`endif
        end else begin
            case (state)
`ifdef SRAM_ARB_CLEAR_EN
                ST_CLEAR: begin
                    if (!clr_cnt[ADDR_W]) begin
                        ram_cen  <= 1'b0;
                        ram_gwen <= 1'b0;
                        ram_wen  <= '0;
                        ram_a    <= clr_cnt[ADDR_W-1:0];
                        ram_d    <= '0;
                        clr_cnt  <= clr_cnt + (ADDR_W+1)'(1);
                    end else begin
                        ram_cen  <= 1'b1;
                        ram_gwen <= 1'b1;
                        ram_wen  <= '1;
                        state    <= ST_IDLE;
                    end
                end
`endif
                ST_IDLE: begin
                    if (grant_a) begin
                        ram_cen <= 1'b0;
                        ram_a   <= bus.a_addr;
                        gnt_b   <= 1'b0;
                        last_b  <= 1'b0;
                        is_rd   <= !bus.a_we;
                        if (bus.a_we) begin
                            ram_gwen <= 1'b0;
                            ram_wen  <= '0;
                            ram_d    <= bus.a_wdata;
                        end else begin
                            ram_gwen <= 1'b1;
                            ram_wen  <= '1;
                        end
                        state <= ST_CMD;
                    end else if (bus.b_req) begin
                        ram_cen <= 1'b0;
                        ram_a   <= bus.b_addr;
                        gnt_b   <= 1'b1;
                        last_b  <= 1'b1;
                        is_rd   <= !bus.b_we;
                        if (bus.b_we) begin
                            ram_gwen <= 1'b0;
                            ram_wen  <= ~bus.b_wbmask;
                            ram_d    <= bus.b_wdata;
                        end else begin
                            ram_gwen <= 1'b1;
                            ram_wen  <= '1;
                        end
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    ram_cen  <= 1'b1;
                    ram_gwen <= 1'b1;
                    ram_wen  <= '1;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (gnt_b) begin
                        b_ack <= 1'b1;
                        if (is_rd) b_rdata <= bus.ram_q;
                    end else begin
                        a_ack <= 1'b1;
                        if (is_rd) a_rdata <= bus.ram_q;
                    end
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ram_cen  = ram_cen;
    assign bus.ram_gwen = ram_gwen;
    assign bus.ram_wen  = ram_wen;
    assign bus.ram_a    = ram_a;
    assign bus.ram_d    = ram_d;
    assign bus.a_ack    = a_ack;
    assign bus.b_ack    = b_ack;
    assign bus.a_rdata  = a_rdata;
    assign bus.b_rdata  = b_rdata;
`ifdef SRAM_ARB_CLEAR_EN
    assign bus.busy     = (state == ST_CLEAR);
`else
    assign bus.busy     = 1'b0;
`endif
endmodule

// File: tb/tb_as2650_sram_arbiter.sv
// tb/tb_as2650_sram_arbiter.sv - directed bench for as2650_sram_arbiter with a behavioural 512x8 macro
module tb_as2650_sram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    as2650_sram_arbiter_if #(.ADDR_W(9), .DATA_W(8)) bus ();

    as2650_sram_arbiter #(.ADDR_W(9), .DATA_W(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

`ifdef SRAM_ARB_CLEAR_EN
    localparam logic [7:0] POST_RST_EXP = 8'h00;
`else
    localparam logic [7:0] POST_RST_EXP = 8'h5A;
`endif

    logic [7:0] mem [512];
    logic [7:0] m_tmp;
    always @(posedge clk) begin
        if (!bus.ram_cen) begin
            m_tmp = mem[bus.ram_a];
            if (!bus.ram_gwen) begin
                for (int i = 0; i < 8; i++)
                    if (!bus.ram_wen[i]) m_tmp[i] = bus.ram_d[i];
                mem[bus.ram_a] <= m_tmp;
            end
            bus.ram_q <= m_tmp;
        end
    end

    int         tests = 0;
    int         fails = 0;
    int         cen_low = 0;
    logic [7:0] last_wen = 8'hFF;
    logic       busy_seen = 1'b0;

    always @(negedge clk) begin
        if (!bus.ram_cen) begin
            cen_low  = cen_low + 1;
            last_wen = bus.ram_wen;
        end
        if (bus.busy && !rst) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after ack has fallen.
    task automatic access(input bit port_b, input bit we, input logic [8:0] addr,
                          input logic [7:0] wdata, input logic [7:0] mask,
                          output logic [7:0] rdata, output int lat);
        cen_low = 0;
        if (!port_b) begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end else begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
            bus.b_wbmask = mask;
        end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (port_b ? bus.b_ack : bus.a_ack) begin
                lat = n - 1;
                break;
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        rdata = port_b ? bus.b_rdata : bus.a_rdata;
        @(negedge clk);
        check("ack_fall", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 600 && bus.busy; n++) @(negedge clk);
        if (bus.busy) check("busy_timeout", 32'(bus.busy), 32'd0);
    endtask

    logic [7:0]  rd;
    int          lat;
    logic [15:0] amask;
    logic [15:0] bmask;
    int          busy_n;
    logic        early;

    initial begin
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0; bus.b_wbmask = 0;
        repeat (3) @(negedge clk);
        check("rst_cen",  32'(bus.ram_cen), 32'd1);
        check("rst_gwen", 32'(bus.ram_gwen), 32'd1);
        check("rst_wen",  32'(bus.ram_wen), 32'hFF);
        check("rst_a",    32'(bus.ram_a), 32'd0);
        check("rst_d",    32'(bus.ram_d), 32'd0);
        check("rst_ack",  {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
        check("rst_ardata", 32'(bus.a_rdata), 32'd0);
        check("rst_brdata", 32'(bus.b_rdata), 32'd0);

        rst = 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
        wait_ready();
`endif
        // Without the sweep, this request is sampled on the first edge after release.
        access(0, 1, 9'h1FF, 8'h5A, 8'h00, rd, lat);
        check("a_wr_lat", 32'(lat), 32'd2);
        check("a_wr_cen", 32'(cen_low), 32'd1);
        check("a_wr_wen", 32'(last_wen), 32'h00);
        access(0, 0, 9'h1FF, 8'h00, 8'h00, rd, lat);
        check("a_rd_lat", 32'(lat), 32'd2);
        check("a_rd_cen", 32'(cen_low), 32'd1);
        check("a_rd_data", 32'(rd), 32'h5A);
        access(0, 1, 9'h0AA, 8'h33, 8'h00, rd, lat);
        check("a_wr_keeps_rdata", 32'(bus.a_rdata), 32'h5A);

        access(1, 1, 9'h010, 8'h00, 8'hFF, rd, lat);
        access(1, 1, 9'h010, 8'hFF, 8'h0F, rd, lat);
        check("b_wr_lat", 32'(lat), 32'd2);
        check("b_wr_wen", 32'(last_wen), 32'hF0);
        access(1, 0, 9'h010, 8'h00, 8'h00, rd, lat);
        check("b_rd_data", 32'(rd), 32'h0F);
        access(1, 1, 9'h010, 8'hAA, 8'h00, rd, lat);
        check("b_mask0_lat", 32'(lat), 32'd2);
        check("b_mask0_wen", 32'(last_wen), 32'hFF);
        access(1, 0, 9'h010, 8'h00, 8'h00, rd, lat);
        check("b_mask0_data", 32'(rd), 32'h0F);

        // Last grant was B, so A wins the first contention.
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 9'h1FF;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 9'h010;
        amask = 0; bmask = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            amask[n] = bus.a_ack;
            bmask[n] = bus.b_ack;
        end
        bus.a_req = 0; bus.b_req = 0;
        check("cont_a_acks", 32'(amask), 32'h0404);
        check("cont_b_acks", 32'(bmask), 32'h4040);
        check("cont_a_data", 32'(bus.a_rdata), 32'h5A);
        check("cont_b_data", 32'(bus.b_rdata), 32'h0F);
        repeat (2) @(negedge clk);

        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 9'h010;
        @(negedge clk);
        @(negedge clk);
        rst = 1; bus.a_req = 0;
        @(negedge clk);
        check("mid_rst_ack",  32'(bus.a_ack), 32'd0);
        check("mid_rst_cen",  32'(bus.ram_cen), 32'd1);
        check("mid_rst_gwen", 32'(bus.ram_gwen), 32'd1);
        check("mid_rst_wen",  32'(bus.ram_wen), 32'hFF);
        check("mid_rst_a",    32'(bus.ram_a), 32'd0);
        check("mid_rst_d",    32'(bus.ram_d), 32'd0);
        check("mid_rst_rdata", 32'(bus.a_rdata), 32'd0);
        rst = 0;
        wait_ready();
        access(0, 0, 9'h1FF, 8'h00, 8'h00, rd, lat);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_data", 32'(rd), 32'(POST_RST_EXP));

`ifdef SRAM_ARB_CLEAR_EN
        access(0, 1, 9'h123, 8'hAA, 8'h00, rd, lat);
        rst = 1;
        @(negedge clk);
        check("clr_busy_rst", 32'(bus.busy), 32'd1);
        rst = 0;
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 9'h123;
        busy_n = 0; early = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (bus.a_ack) early = 1;
            if (!bus.busy) break;
            busy_n++;
        end
        check("clr_busy_len", 32'(busy_n), 32'd512);
        check("clr_no_early_ack", 32'(early), 32'd0);
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.a_ack) begin lat = n; break; end
        end
        bus.a_req = 0;
        check("clr_ack_lat", 32'(lat), 32'd3);
        check("clr_rdata", 32'(bus.a_rdata), 32'h00);
        repeat (2) @(negedge clk);
`else
        check("busy_never", 32'(busy_seen), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
